// File: rtl/clock_core_mux.sv
// Digital clock core: seconds prescaler, BCD timekeeper, two-button set FSM
// and a 4-digit multiplexed 7-segment driver with blink, colon and polarity.
module clock_core_mux #(
  parameter int TICKS_PER_SEC  = 27000000,
  parameter int SCAN_DIV       = 6750,
  parameter int DEBOUNCE_CYC   = 270000,
  parameter int BLINK_DIV      = 6750000,
  parameter bit H24            = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       mode_n,
  input  logic       set_n,
  output logic [6:0] seg,
  output logic [3:0] dig_sel,
  output logic       colon,
  output logic [1:0] mode_state,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd
);

  typedef enum logic [1:0] {RUN = 2'b00, SET_MIN = 2'b01, SET_HR = 2'b10} state_t;

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SW = (SCAN_DIV > 1)      ? $clog2(SCAN_DIV)      : 1;
  localparam int DW = (DEBOUNCE_CYC > 1)  ? $clog2(DEBOUNCE_CYC)  : 1;
  localparam int BW = (BLINK_DIV > 1)     ? $clog2(BLINK_DIV)     : 1;

  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICKS_PER_SEC / 2);
  localparam logic [SW-1:0] SCAN_MAX   = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_MAX     = DW'(DEBOUNCE_CYC - 1);
  localparam logic [BW-1:0] BLINK_MAX  = BW'(BLINK_DIV - 1);
  localparam logic [7:0]    HR_RST     = H24 ? 8'h00 : 8'h12;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc60(input logic [7:0] v);
    inc60 = (v == 8'h59) ? 8'h00 : bcd_inc(v);
  endfunction

  function automatic logic [7:0] inc_hr(input logic [7:0] v);
    if (H24) inc_hr = (v == 8'h23) ? 8'h00 : bcd_inc(v);
    else     inc_hr = (v == 8'h12) ? 8'h01 : bcd_inc(v);
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b0111111;
      4'd1:    seg_enc = 7'b0000110;
      4'd2:    seg_enc = 7'b1011011;
      4'd3:    seg_enc = 7'b1001111;
      4'd4:    seg_enc = 7'b1100110;
      4'd5:    seg_enc = 7'b1101101;
      4'd6:    seg_enc = 7'b1111101;
      4'd7:    seg_enc = 7'b0000111;
      4'd8:    seg_enc = 7'b1111111;
      4'd9:    seg_enc = 7'b1101111;
      default: seg_enc = 7'b0000000;
    endcase
  endfunction

  // Button index 1 = mode, 0 = set; idle level is high.
  logic [1:0]          s1_q, s1_d, s2_q, s2_d, db_q, db_d, press;
  logic [1:0][DW-1:0]  dbc_q, dbc_d;

  state_t              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [7:0]          hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic [SW-1:0]       scan_q, scan_d;
  logic [1:0]          idx_q, idx_d;
  logic [BW-1:0]       blink_q, blink_d;
  logic                phase_q, phase_d;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          dig_q, dig_d;
  logic                colon_q, colon_d;
  logic                sec_tick, mode_p, set_p, blank;
  logic [3:0]          digit;

  always_comb begin
    s1_d  = {mode_n, set_n};
    s2_d  = s1_q;
    db_d  = db_q;
    dbc_d = '0;
    press = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DB_MAX) begin
          db_d[i]  = s2_q[i];
          press[i] = ~s2_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    hr_d     = hr_q;
    min_d    = min_q;
    sec_d    = sec_q;
    mode_p   = press[1];
    set_p    = press[0];
    sec_tick = (state_q == RUN) && (presc_q == PRESC_MAX);

    case (state_q)
      RUN: begin
        if (sec_tick) begin
          sec_d = inc60(sec_q);
          if (sec_q == 8'h59) begin
            min_d = inc60(min_q);
            if (min_q == 8'h59) hr_d = inc_hr(hr_q);
          end
        end
        // Tick applies first; entering SET_MIN then clears seconds.
        if (mode_p) begin
          state_d = SET_MIN;
          sec_d   = 8'h00;
        end
      end
      SET_MIN: begin
        if (mode_p)     state_d = SET_HR;
        else if (set_p) min_d   = inc60(min_q);
      end
      SET_HR: begin
        if (mode_p)     state_d = RUN;
        else if (set_p) hr_d    = inc_hr(hr_q);
      end
      default: state_d = RUN;
    endcase

    // Held at 0 on both the entry and exit edges of the set states so the
    // first tick after returning to RUN is a full second away.
    if (state_q != RUN || state_d != RUN) presc_d = '0;
    else if (sec_tick)                    presc_d = '0;
    else                                  presc_d = presc_q + 1'b1;

    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_MAX) begin
      scan_d = '0;
      idx_d  = idx_q + 1'b1;
    end

    blink_d = blink_q + 1'b1;
    phase_d = phase_q;
    if (blink_q == BLINK_MAX) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end

    case (idx_d)
      2'd3:    digit = hr_q[7:4];
      2'd2:    digit = hr_q[3:0];
      2'd1:    digit = min_q[7:4];
      default: digit = min_q[3:0];
    endcase
    blank   = phase_q && (((state_q == SET_MIN) && !idx_d[1]) ||
                          ((state_q == SET_HR)  &&  idx_d[1]));
    seg_d   = blank ? 7'b0000000 : seg_enc(digit);
    dig_d   = 4'b0001 << idx_d;
    colon_d = (state_d != RUN) || (presc_d < PRESC_HALF);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      s1_q    <= 2'b11;
      s2_q    <= 2'b11;
      db_q    <= 2'b11;
      dbc_q   <= '0;
      state_q <= RUN;
      presc_q <= '0;
      hr_q    <= HR_RST;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      scan_q  <= '0;
      idx_q   <= 2'd0;
      blink_q <= '0;
      phase_q <= 1'b0;
      seg_q   <= 7'b0111111;
      dig_q   <= 4'b0001;
      colon_q <= 1'b1;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      db_q    <= db_d;
      dbc_q   <= dbc_d;
      state_q <= state_d;
      presc_q <= presc_d;
      hr_q    <= hr_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      colon_q <= colon_d;
    end
  end

  assign seg        = SEG_ACTIVE_LOW ? ~seg_q   : seg_q;
  assign colon      = SEG_ACTIVE_LOW ? ~colon_q : colon_q;
  assign dig_sel    = DIG_ACTIVE_LOW ? ~dig_q   : dig_q;
  assign mode_state = state_q;
  assign hr_bcd     = hr_q;
  assign min_bcd    = min_q;
  assign sec_bcd    = sec_q;

endmodule

// File: tb/tb_clock_core_mux.sv
module tb_clock_core_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, mode_a, set_a, rst_b, mode_b, set_b;
  logic [6:0] seg_a, seg_b;
  logic [3:0] dig_a, dig_b;
  logic       col_a, col_b;
  logic [1:0] ms_a, ms_b;
  logic [7:0] hr_a, min_a, sec_a, hr_b, min_b, sec_b;

  clock_core_mux #(
    .TICKS_PER_SEC(10), .SCAN_DIV(4), .DEBOUNCE_CYC(3), .BLINK_DIV(20),
    .H24(1'b1), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut_a (
    .sys_clk(clk), .reset(rst_a), .mode_n(mode_a), .set_n(set_a),
    .seg(seg_a), .dig_sel(dig_a), .colon(col_a), .mode_state(ms_a),
    .hr_bcd(hr_a), .min_bcd(min_a), .sec_bcd(sec_a)
  );

  clock_core_mux #(
    .TICKS_PER_SEC(10), .SCAN_DIV(4), .DEBOUNCE_CYC(3), .BLINK_DIV(20),
    .H24(1'b0), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut_b (
    .sys_clk(clk), .reset(rst_b), .mode_n(mode_b), .set_n(set_b),
    .seg(seg_b), .dig_sel(dig_b), .colon(col_b), .mode_state(ms_b),
    .hr_bcd(hr_b), .min_bcd(min_b), .sec_bcd(sec_b)
  );

  localparam int F_MODE = 0, F_HR = 1, F_MIN = 2, F_SEC = 3,
                 F_SEG = 4, F_DIG = 5, F_COL = 6, B_OFS = 8;

  logic [6:0] enc [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct {
    int         sel;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t sb[$];
  int   n_pass = 0, n_tot = 0;
  int   cyc = 0;
  int   base;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] act(input int sel);
    case (sel)
      F_MODE:         return {6'd0, ms_a};
      F_HR:           return hr_a;
      F_MIN:          return min_a;
      F_SEC:          return sec_a;
      F_SEG:          return {1'b0, seg_a};
      F_DIG:          return {4'd0, dig_a};
      F_COL:          return {7'd0, col_a};
      B_OFS + F_MODE: return {6'd0, ms_b};
      B_OFS + F_HR:   return hr_b;
      B_OFS + F_MIN:  return min_b;
      B_OFS + F_SEC:  return sec_b;
      B_OFS + F_SEG:  return {1'b0, seg_b};
      B_OFS + F_DIG:  return {4'd0, dig_b};
      B_OFS + F_COL:  return {7'd0, col_b};
      default:        return 8'hxx;
    endcase
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  chk_t       mc;
  logic [7:0] ma;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mc = sb.pop_front();
      ma = act(mc.sel);
      n_tot = n_tot + 1;
      if (ma === mc.exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", mc.name, ma, mc.exp, cyc);
    end
  end

  task automatic check_now(input bit ok, input string nm);
    n_tot = n_tot + 1;
    if (ok) n_pass = n_pass + 1;
    else    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic push_exp(input int sel, input logic [7:0] e, input string nm);
    chk_t c;
    c.sel = sel; c.exp = e; c.name = nm;
    sb.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit on_b, input bit m, input bit s);
    if (on_b) begin
      if (m) mode_b = 1'b0;
      if (s) set_b  = 1'b0;
    end else begin
      if (m) mode_a = 1'b0;
      if (s) set_a  = 1'b0;
    end
    tick(8);
    mode_a = 1'b1; set_a = 1'b1; mode_b = 1'b1; set_b = 1'b1;
    tick(8);
  endtask

  initial begin
    int k, idx, w;
    logic [3:0] dv;
    logic       ph;

    rst_a = 1'b1; rst_b = 1'b1;
    mode_a = 1'b1; set_a = 1'b1; mode_b = 1'b1; set_b = 1'b1;

    tick(1);
    check_now((ms_a === 2'b00) && (hr_a === 8'h00) && (min_a === 8'h00) &&
              (sec_a === 8'h00) && (seg_a === 7'h3F) && (dig_a === 4'b0001) &&
              (col_a === 1'b1) && (hr_b === 8'h12), "rst_direct");
    rst_a = 1'b0;
    base  = cyc;
    push_exp(F_MODE, 8'h00, "rst_mode");
    push_exp(F_HR,   8'h00, "rst_hr");
    push_exp(F_MIN,  8'h00, "rst_min");
    push_exp(F_SEC,  8'h00, "rst_sec");
    push_exp(F_SEG,  8'h3F, "rst_seg");
    push_exp(F_DIG,  8'h01, "rst_dig");
    push_exp(F_COL,  8'h01, "rst_colon");
    for (int j = 1; j <= 600; j++) begin
      tick(1);
      push_exp(F_SEC, bcd((j / 10) % 60), "run_sec");
      push_exp(F_MIN, bcd(j / 600), "run_min");
      push_exp(F_DIG, 8'(4'b0001 << ((j / 4) % 4)), "run_dig");
      push_exp(F_COL, ((j % 10) < 5) ? 8'h01 : 8'h00, "run_colon");
      push_exp(F_SEG, 8'h3F, "run_seg");
    end
    push_exp(F_HR, 8'h00, "run_hr");

    mode_a = 1'b0; tick(2); mode_a = 1'b1; tick(10);
    push_exp(F_MODE, 8'h00, "glitch_mode");
    mode_a = 1'b0; tick(10);
    push_exp(F_MODE, 8'h01, "hold_mode");
    push_exp(F_SEC,  8'h00, "set_min_sec_clr");
    mode_a = 1'b1; tick(8);
    push_exp(F_MODE, 8'h01, "release_mode");

    press(0, 0, 1);
    push_exp(F_MIN, 8'h02, "set_min_1");
    repeat (57) press(0, 0, 1);
    push_exp(F_MIN, 8'h59, "set_min_58");
    press(0, 0, 1);
    push_exp(F_MIN, 8'h00, "set_min_wrap");
    push_exp(F_HR,  8'h00, "set_min_no_carry");
    press(0, 0, 1);
    push_exp(F_MIN, 8'h01, "set_min_60");
    press(0, 1, 1);
    push_exp(F_MODE, 8'h02, "simul_mode");
    push_exp(F_MIN,  8'h01, "simul_min");

    repeat (23) press(0, 0, 1);
    push_exp(F_HR, 8'h23, "set_hr_23");
    press(0, 1, 0);
    push_exp(F_MODE, 8'h00, "to_run");
    press(0, 1, 0);
    push_exp(F_MODE, 8'h01, "to_set_min");
    push_exp(F_SEC,  8'h00, "sec_clr2");
    repeat (58) press(0, 0, 1);
    push_exp(F_MIN, 8'h59, "set_min_59");
    press(0, 1, 0);
    push_exp(F_MODE, 8'h02, "to_set_hr");
    mode_a = 1'b0;
    w = 0;
    while (ms_a != 2'b00 && w < 20) begin
      tick(1);
      w++;
    end
    check_now(w < 20, "ret_run_wait_expired");
    mode_a = 1'b1;
    push_exp(F_MODE, 8'h00, "ret_run");
    for (int j = 1; j <= 600; j++) begin
      tick(1);
      if (j == 9)  push_exp(F_SEC, 8'h00, "pre_first_tick");
      if (j == 10) push_exp(F_SEC, 8'h01, "first_tick");
      if (j == 590) begin
        push_exp(F_HR,  8'h23, "pre_mid_hr");
        push_exp(F_MIN, 8'h59, "pre_mid_min");
        push_exp(F_SEC, 8'h59, "pre_mid_sec");
      end
    end
    push_exp(F_HR,  8'h00, "mid_hr");
    push_exp(F_MIN, 8'h00, "mid_min");
    push_exp(F_SEC, 8'h00, "mid_sec");

    rst_a = 1'b1; tick(1); rst_a = 1'b0;
    base = cyc;
    press(0, 1, 0);
    press(0, 1, 0);
    press(0, 0, 1);
    push_exp(F_MODE, 8'h02, "blink_mode");
    push_exp(F_HR,   8'h01, "blink_hr");
    for (int j = 0; j < 80; j++) begin
      tick(1);
      k   = cyc - base;
      idx = (k / 4) % 4;
      ph  = (((k - 1) / 20) % 2) == 1;
      dv  = (idx == 2) ? 4'd1 : 4'd0;
      push_exp(F_DIG, 8'(4'b0001 << idx), "blink_dig");
      push_exp(F_SEG, (ph && idx >= 2) ? 8'h00 : {1'b0, enc[dv]}, "blink_seg");
      push_exp(F_COL, 8'h01, "set_colon");
    end

    push_exp(B_OFS + F_HR,   8'h12, "b_rst_hr");
    push_exp(B_OFS + F_SEG,  8'h40, "b_rst_seg");
    push_exp(B_OFS + F_DIG,  8'h0E, "b_rst_dig");
    push_exp(B_OFS + F_COL,  8'h00, "b_rst_colon");
    push_exp(B_OFS + F_MODE, 8'h00, "b_rst_mode");
    rst_b = 1'b0;
    press(1, 1, 0);
    press(1, 1, 0);
    push_exp(B_OFS + F_MODE, 8'h02, "b_set_hr");
    press(1, 0, 1);
    push_exp(B_OFS + F_HR, 8'h01, "b_hr_01");
    repeat (8) press(1, 0, 1);
    push_exp(B_OFS + F_HR, 8'h09, "b_hr_09");
    press(1, 0, 1);
    push_exp(B_OFS + F_HR, 8'h10, "b_hr_10");
    repeat (2) press(1, 0, 1);
    push_exp(B_OFS + F_HR, 8'h12, "b_hr_12");
    press(1, 0, 1);
    push_exp(B_OFS + F_HR, 8'h01, "b_hr_wrap");

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/clock_core_mux.md
Name: clock_core_mux

Overview:
- Parametrised digital-clock core and the successor to the fixed 4-digit clock top.
- Contains a seconds prescaler, a BCD hours/minutes/seconds timekeeper, a debounced two-button set FSM, and a 4-digit multiplexed 7-segment driver.
- Adds a 12/24-hour mode, a blinking edit field, a colon output and selectable output polarity.
- Sits between the board pins (buttons, segments, digit selects) and sys_clk; all timing is derived from parameters in sys_clk cycles.

Parameters:
- TICKS_PER_SEC, 27000000, sys_clk cycles per second.
- SCAN_DIV, 6750, sys_clk cycles each digit stays selected.
- DEBOUNCE_CYC, 270000, consecutive stable cycles required to accept a button level.
- BLINK_DIV, 6750000, sys_clk cycles per blink half-period.
- H24, 1, 1 = 24-hour mode (hours 0..23); 0 = 12-hour mode (hours 1..12, no AM/PM).
- SEG_ACTIVE_LOW, 0, 1 inverts seg and colon at the output.
- DIG_ACTIVE_LOW, 0, 1 inverts dig_sel at the output.

Ports:
- sys_clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mode_n  in  1  mode button, asynchronous, low = pressed.
- set_n  in  1  set button, asynchronous, low = pressed.
- seg  out  7  segments {g,f,e,d,c,b,a}, registered.
- dig_sel  out  4  one-hot digit select; bit3 = hour tens ... bit0 = minute ones; registered.
- colon  out  1  colon LED, registered.
- mode_state  out  2  00 RUN, 01 SET_MIN, 10 SET_HR.
- hr_bcd  out  8  hours as BCD {tens, ones}.
- min_bcd  out  8  minutes as BCD.
- sec_bcd  out  8  seconds as BCD.

Behaviour:
- Reset (sampled at the sys_clk edge while reset=1):
  - State RUN; prescaler, scan, blink and debounce counters = 0; blink_phase = 0.
  - Time = 00:00:00 when H24=1, 12:00:00 when H24=0.
  - dig_sel = 0001 and seg = 0111111 ('0'), both before polarity inversion; colon = 1 (prescaler = 0).
  - Reset asserted mid-operation discards any pending press and restores all of the above on the next edge.
- Button input:
  - Each button passes through a 2-flop synchroniser.
  - A debounced level updates only after DEBOUNCE_CYC consecutive identical synchronised samples.
  - A press event is a one-cycle pulse on a debounced 1->0 transition. Release generates nothing, and holding a button generates exactly one event.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 in RUN only; sec_tick pulses for one cycle when the count equals TICKS_PER_SEC-1.
  - In SET_MIN and SET_HR the prescaler is held at 0.
  - After returning to RUN, the first sec_tick occurs exactly TICKS_PER_SEC cycles later.
- Timekeeping in RUN, on sec_tick:
  - Seconds count 00..59; 59 wraps to 00 and carries to minutes.
  - Minutes count 00..59; 59 wraps to 00 and carries to hours.
  - Hours wrap 23->00 (H24=1) or 12->01 (H24=0).
  - All values are stored as BCD; no invalid BCD nibble is ever produced.
- Mode FSM on a mode press:
  - RUN->SET_MIN: sec_bcd is cleared to 00.
  - SET_MIN->SET_HR.
  - SET_HR->RUN.
- Set press:
  - In SET_MIN: minutes +1, wrapping 59->00 with no carry to hours.
  - In SET_HR: hours +1 with the same wrap as timekeeping.
  - In RUN: ignored.
- Simultaneous events:
  - A mode press and a set press in the same cycle: mode wins and set is dropped.
  - A sec_tick and a mode press in the same cycle in RUN: the tick increment applies, then the state changes.
- Display scan:
  - Digit index advances 0->1->2->3->0 every SCAN_DIV cycles.
  - seg and dig_sel update on the same edge, from time values one cycle old.
- Blink:
  - blink_phase toggles every BLINK_DIV cycles, in all states.
  - In SET_MIN the minute digits show seg = 0000000 while blink_phase = 1; in SET_HR the hour digits do so. dig_sel keeps scanning.
- Colon: 1 while prescaler < TICKS_PER_SEC/2 in RUN; constant 1 in set states.
- Segment encoding (7-bit patterns for digits 0..9): 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111.
- Polarity inversion is applied last and combinationally on the registered values.

Test Plan (TICKS_PER_SEC=10, SCAN_DIV=4, DEBOUNCE_CYC=3, BLINK_DIV=20, H24=1 unless stated):
1. Reset, then run 600 cycles -> sec_bcd 00->59 once, then min_bcd=01, sec_bcd=00, hr_bcd=00; dig_sel cycles 0001,0010,0100,1000 every 4 cycles; colon high for 5 of every 10 cycles.
2. mode_n low for 2 cycles (glitch) -> mode_state stays 00. Then low for 10 cycles -> exactly one transition to 01; sec_bcd=00.
3. In SET_MIN: 60 set presses -> min_bcd returns to its start value via 59->00, hr_bcd unchanged. A mode press and a set press in the same cycle -> state 10, minutes unchanged.
4. Set the time to 23:59 via presses, then return to RUN -> first sec_tick 10 cycles after the transition; after 600 cycles time = 00:00:00.
5. H24=0: reset -> hr_bcd=0x12. In SET_HR, one set press -> 0x01; eleven more -> 0x12.
6. SET_HR with blink_phase=1 -> seg=0000000 on dig_sel bits 3/2, minute digits are decoded normally. With SEG_ACTIVE_LOW=1, the reset seg value is 1000000.
